scan: RTL and testbench
=======================

// Module: scan
// PURPOSE
// - Input-conditioning and scan-mode selector for the VGA datapath.
// - Takes two asynchronous level enables (EN_in1, EN_in0), synchronises and debounces each one, and
//   presents the stable pair as the 2-bit scan-mode code sdata to the downstream scan/timing logic.
// - Emits a one-cycle pulse whenever the code changes.
// PARAMETERS
// - SYNC_STAGES  2  flip-flop stages in each input synchroniser; legal range >=2
// - DEB_CYCLES   4  consecutive synchronised cycles an input must differ from its stable value
//                   before it is accepted; legal range >=1
// - CNT_W        $clog2(DEB_CYCLES+1)  debounce counter width (derived; do not override)
// PORTS
// - clk        in   1  system clock; all logic on rising edge
// - rst_n      in   1  reset, synchronous, active-low
// - EN_in1     in   1  asynchronous enable, bit 1 of the mode code
// - EN_in0     in   1  asynchronous enable, bit 0 of the mode code
// - sdata      out  2  registered scan-mode code {stable EN_in1, stable EN_in0}
// - sdata_chg  out  1  one-cycle pulse, asserted in the cycle after sdata takes a new value
// BEHAVIOUR
// - Reset (rst_n=0 at a rising edge):
//   - all synchroniser flops, stable bits and counters go to 0
//   - sdata=2'b00, sdata_chg=0
//   - reset asserted mid-debounce discards the count
// - Per input, independent and identical:
//   - raw input -> SYNC_STAGES-deep flop chain -> s (synchronised value)
//   - if s==stable: cnt<=0
//   - else if cnt==DEB_CYCLES-1: stable<=s, cnt<=0
//   - else: cnt<=cnt+1
// - sdata is {stable1, stable0}; no combinational path from EN_in* to sdata.
// - Latency: an input level held constant appears on sdata exactly SYNC_STAGES+DEB_CYCLES rising
//   edges after the first edge that samples it.
//   - default parameters: 6 edges
// - Glitch rejection:
//   - a change lasting fewer than DEB_CYCLES synchronised cycles never reaches sdata
//   - its counter returns to 0 when it reverts
// - Simultaneous changes:
//   - both bits changing in the same cycle update sdata on the same edge
//   - sdata_chg pulses once
// - sdata_chg:
//   - register = (sdata_next != sdata)
//   - high for exactly one cycle per update
//   - never high during or in the first cycle after reset
// - Mode codes:
//   - 00 = idle/blank
//   - 01 = scan mode A (EN_in0)
//   - 10 = scan mode B (EN_in1)
//   - 11 = both enabled
//   - the code is a direct pass-through of the stable levels; no priority encoding
// STRUCTURE
// - Package scan_pkg:
//   - localparam SDATA_W=2
//   - typedef logic [SDATA_W-1:0] scan_mode_t
//   - named constants SCAN_IDLE=2'b00, SCAN_A=2'b01, SCAN_B=2'b10, SCAN_AB=2'b11
// - Sub-module scan_debounce (params SYNC_STAGES, DEB_CYCLES; ports clk, rst_n, din, dout):
//   - holds the synchroniser, counter and stable flop
//   - instantiated twice, once per input
// - Top level holds only the two instances, the sdata assembly and the sdata_chg register.
// TESTING (defaults SYNC_STAGES=2, DEB_CYCLES=4; clk period 10 ns)
// - Reset: rst_n=0 for 3 edges with EN_in1=1, EN_in0=1
//   -> sdata=00, sdata_chg=0 throughout reset and in the first cycle after release
// - Step: after reset raise EN_in0 to 1 and hold
//   -> sdata=01 on the 6th edge; sdata_chg=1 for exactly the following cycle
// - Glitch: pulse EN_in1 high for 2 cycles then low
//   -> sdata stays 01; sdata_chg stays 0
// - Simultaneous change: EN_in1 0->1 and EN_in0 1->0 in the same cycle
//   -> sdata goes 01->10 on a single edge 6 edges later; one sdata_chg pulse
// - Reset mid-debounce: start an EN_in1 change, assert rst_n=0 after 3 edges
//   -> sdata=00 and counters cleared; after release, a held input again needs the full 6 edges
// - Async input: toggle EN_in0 off-grid, 3 ns after a clock edge
//   -> sdata never takes a value other than 00 or 01; no X on sdata at any time

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and mode-code constants for the scan-mode selector.
package scan_pkg;

  localparam int SDATA_W = 2;

  typedef logic [SDATA_W-1:0] scan_mode_t;

  // Mode codes are a direct pass-through of the two stable enable levels.
  localparam scan_mode_t SCAN_IDLE = 2'b00;  // idle / blank
  localparam scan_mode_t SCAN_A    = 2'b01;  // scan mode A (EN_in0)
  localparam scan_mode_t SCAN_B    = 2'b10;  // scan mode B (EN_in1)
  localparam scan_mode_t SCAN_AB   = 2'b11;  // both enabled

endpackage

// File: rtl/scan_debounce.sv
// One input channel: multi-flop synchroniser followed by a counting debouncer.
// dout is the accepted stable level; dout_nxt is the value dout takes at the
// next rising edge, so the parent can register a change pulse without adding
// latency to dout.
module scan_debounce
  import scan_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic dout_nxt
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_s;
  logic                   w_differs;
  logic                   w_accept;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_s != r_stable);
  assign w_accept  = w_differs && (r_cnt == CNT_W'(DEB_CYCLES - 1));

  // Shift the raw asynchronous level through the synchroniser chain.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      // NOTE: the synchroniser flops are reset too, so a level captured before
      // reset cannot leak into the debouncer after release.
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  // Count consecutive cycles of disagreement; accept after DEB_CYCLES of them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_differs) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_stable <= w_s;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign dout     = r_stable;
  assign dout_nxt = w_accept ? w_s : r_stable;

endmodule

// File: rtl/scan.sv
// Scan-mode selector: conditions the two asynchronous enables and presents
// the stable pair as a 2-bit mode code, plus a one-cycle change pulse.
module scan
  import scan_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               EN_in1,
  input  logic               EN_in0,
  output logic [SDATA_W-1:0] sdata,
  output logic               sdata_chg
);

  logic       w_stable1;
  logic       w_stable0;
  logic       w_nxt1;
  logic       w_nxt0;
  scan_mode_t w_sdata;
  scan_mode_t w_sdata_nxt;
  logic       r_sdata_chg;

  scan_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_deb1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (EN_in1),
    .dout     (w_stable1),
    .dout_nxt (w_nxt1)
  );

  scan_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_deb0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (EN_in0),
    .dout     (w_stable0),
    .dout_nxt (w_nxt0)
  );

  // Both stable bits are flops, so sdata has no combinational path from EN_in*.
  assign w_sdata     = {w_stable1, w_stable0};
  assign w_sdata_nxt = {w_nxt1, w_nxt0};

  // Register a pulse in the same edge that sdata changes, so it is high for
  // exactly the cycle following the update; both bits moving together give one pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sdata_chg <= 1'b0;
    end else begin
      r_sdata_chg <= (w_sdata_nxt != w_sdata);
    end
  end

  assign sdata     = w_sdata;
  assign sdata_chg = r_sdata_chg;

endmodule

// File: tb/tb_scan.sv
// Self-checking bench for the scan-mode selector: directed scenarios plus
// randomized enables compared against a sample-history reference model.
module tb_scan;
  import scan_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 4;
  localparam int LATENCY     = SYNC_STAGES + DEB_CYCLES;

  logic       clk;
  logic       rst_n;
  logic       EN_in1;
  logic       EN_in0;
  logic [1:0] sdata;
  logic       sdata_chg;

  int n_checks;
  int n_fail;

  scan #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN_in1    (EN_in1),
    .EN_in0    (EN_in0),
    .sdata     (sdata),
    .sdata_chg (sdata_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a level is accepted once the value the synchroniser
  // delivers (the raw sample from SYNC_STAGES edges ago) has disagreed with
  // the accepted level on each of the last DEB_CYCLES edges.
  bit         raw_h [2][SYNC_STAGES];
  bit         win_h [2][DEB_CYCLES];
  logic [1:0] m_sdata = 2'b00;
  logic       m_chg   = 1'b0;

  always @(posedge clk) begin
    logic [1:0] in_v;
    logic [1:0] nxt;
    bit         s;
    bit         all_diff;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SYNC_STAGES; i++) raw_h[b][i] = 1'b0;
        for (int i = 0; i < DEB_CYCLES; i++) win_h[b][i] = 1'b0;
      end
      m_sdata = 2'b00;
      m_chg   = 1'b0;
    end else begin
      in_v = {EN_in1, EN_in0};
      for (int b = 0; b < 2; b++) begin
        s = raw_h[b][0];
        for (int i = 0; i < SYNC_STAGES - 1; i++) raw_h[b][i] = raw_h[b][i+1];
        raw_h[b][SYNC_STAGES-1] = in_v[b];
        for (int i = 0; i < DEB_CYCLES - 1; i++) win_h[b][i] = win_h[b][i+1];
        win_h[b][DEB_CYCLES-1] = s;
        all_diff = 1'b1;
        for (int i = 0; i < DEB_CYCLES; i++)
          if (win_h[b][i] == m_sdata[b]) all_diff = 1'b0;
        nxt[b] = all_diff ? s : m_sdata[b];
      end
      m_chg   = (nxt != m_sdata);
      m_sdata = nxt;
    end
  end

  task automatic test_reset();
    rst_n  = 1'b0;
    EN_in1 = 1'b1;
    EN_in0 = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (sdata !== SCAN_IDLE) begin
        n_fail++;
        $display("FAIL reset_sdata edge %0d: got %b expected %b", e, sdata, SCAN_IDLE);
      end
      n_checks++;
      if (sdata_chg !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_chg edge %0d: got %b expected 0", e, sdata_chg);
      end
    end
    rst_n  = 1'b1;
    EN_in1 = 1'b0;
    EN_in0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sdata !== SCAN_IDLE || sdata_chg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got sdata=%b chg=%b expected sdata=00 chg=0", sdata, sdata_chg);
    end
  endtask

  task automatic test_step();
    logic [1:0] exp_d;
    logic       exp_c;
    EN_in0 = 1'b1;
    for (int e = 1; e <= LATENCY + 1; e++) begin
      @(negedge clk);
      exp_d = (e >= LATENCY) ? SCAN_A : SCAN_IDLE;
      exp_c = (e == LATENCY);
      n_checks++;
      if (sdata !== exp_d || sdata_chg !== exp_c) begin
        n_fail++;
        $display("FAIL step edge %0d: got sdata=%b chg=%b expected sdata=%b chg=%b",
                 e, sdata, sdata_chg, exp_d, exp_c);
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] exp_d;
    logic       exp_c;
    EN_in1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    EN_in1 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      n_checks++;
      if (sdata !== SCAN_A || sdata_chg !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch cycle %0d: got sdata=%b chg=%b expected sdata=01 chg=0",
                 e, sdata, sdata_chg);
      end
    end
    // A rejected glitch must leave no partial count behind.
    EN_in1 = 1'b1;
    for (int e = 1; e <= LATENCY + 1; e++) begin
      @(negedge clk);
      exp_d = (e >= LATENCY) ? SCAN_AB : SCAN_A;
      exp_c = (e == LATENCY);
      n_checks++;
      if (sdata !== exp_d || sdata_chg !== exp_c) begin
        n_fail++;
        $display("FAIL glitch_then_hold edge %0d: got sdata=%b chg=%b expected sdata=%b chg=%b",
                 e, sdata, sdata_chg, exp_d, exp_c);
      end
    end
    EN_in1 = 1'b0;
    repeat (LATENCY + 2) @(negedge clk);
    n_checks++;
    if (sdata !== SCAN_A) begin
      n_fail++;
      $display("FAIL glitch_restore: got %b expected %b", sdata, SCAN_A);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_d;
    logic       exp_c;
    EN_in1 = 1'b1;
    EN_in0 = 1'b0;
    for (int e = 1; e <= LATENCY + 1; e++) begin
      @(negedge clk);
      exp_d = (e >= LATENCY) ? SCAN_B : SCAN_A;
      exp_c = (e == LATENCY);
      n_checks++;
      if (sdata !== exp_d || sdata_chg !== exp_c) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d: got sdata=%b chg=%b expected sdata=%b chg=%b",
                 e, sdata, sdata_chg, exp_d, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [1:0] exp_d;
    logic       exp_c;
    EN_in1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      n_checks++;
      if (sdata !== SCAN_IDLE || sdata_chg !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset edge %0d: got sdata=%b chg=%b expected sdata=00 chg=0",
                 e, sdata, sdata_chg);
      end
    end
    rst_n  = 1'b1;
    EN_in1 = 1'b1;
    EN_in0 = 1'b0;
    for (int e = 1; e <= LATENCY + 1; e++) begin
      @(negedge clk);
      exp_d = (e >= LATENCY) ? SCAN_B : SCAN_IDLE;
      exp_c = (e == LATENCY);
      n_checks++;
      if (sdata !== exp_d || sdata_chg !== exp_c) begin
        n_fail++;
        $display("FAIL mid_reset_release edge %0d: got sdata=%b chg=%b expected sdata=%b chg=%b",
                 e, sdata, sdata_chg, exp_d, exp_c);
      end
    end
  endtask

  task automatic test_async_input();
    EN_in1 = 1'b0;
    repeat (LATENCY + 2) @(negedge clk);
    n_checks++;
    if (sdata !== SCAN_IDLE) begin
      n_fail++;
      $display("FAIL async_setup: got %b expected %b", sdata, SCAN_IDLE);
    end
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #3;
      if ($urandom_range(0, 2) == 0) EN_in0 = ~EN_in0;
      @(negedge clk);
      n_checks++;
      if ($isunknown(sdata) || !(sdata == SCAN_IDLE || sdata == SCAN_A)) begin
        n_fail++;
        $display("FAIL async_range cycle %0d: got %b expected 00 or 01", c, sdata);
      end
      n_checks++;
      if (sdata !== m_sdata || sdata_chg !== m_chg) begin
        n_fail++;
        $display("FAIL async_model cycle %0d: got sdata=%b chg=%b expected sdata=%b chg=%b",
                 c, sdata, sdata_chg, m_sdata, m_chg);
      end
    end
  endtask

  task automatic test_random();
    int hold1;
    int hold0;
    hold1 = 0;
    hold0 = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_checks++;
      if (sdata !== m_sdata || sdata_chg !== m_chg) begin
        n_fail++;
        $display("FAIL random cycle %0d: got sdata=%b chg=%b expected sdata=%b chg=%b",
                 c, sdata, sdata_chg, m_sdata, m_chg);
      end
      rst_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      if (hold1 == 0) begin
        EN_in1 = 1'($urandom_range(0, 1));
        hold1  = $urandom_range(1, 9);
      end else begin
        hold1--;
      end
      if (hold0 == 0) begin
        EN_in0 = 1'($urandom_range(0, 1));
        hold0  = $urandom_range(1, 9);
      end else begin
        hold0--;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    EN_in1   = 1'b1;
    EN_in0   = 1'b1;
    test_reset();
    test_step();
    test_glitch();
    test_simultaneous();
    test_reset_mid_debounce();
    test_async_input();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
